// File: rtl/resource_arbiter_if.sv
// Requester-side and resource-side bus of the resource arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic
// (resource branches plus the external resource).
interface resource_arbiter_if #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int HANDLE_WIDTH = 8
);
    logic [N_REQ-1:0]              req_read;
    logic [N_REQ-1:0]              req_write;
    logic [N_REQ*HANDLE_WIDTH-1:0] req_handle;
    logic [N_REQ*DATA_WIDTH-1:0]   req_arg_a;
    logic [N_REQ*DATA_WIDTH-1:0]   req_arg_b;
    logic [N_REQ-1:0]              req_read_valid;
    logic [N_REQ-1:0]              req_write_ack;
    logic [DATA_WIDTH-1:0]         req_data;
    logic                          res_read_req;
    logic                          res_write_req;
    logic [HANDLE_WIDTH-1:0]       res_handle;
    logic [DATA_WIDTH-1:0]         res_arg_a;
    logic [DATA_WIDTH-1:0]         res_arg_b;
    logic [DATA_WIDTH-1:0]         res_data;
    logic                          res_read_valid;
    logic                          res_write_ack;

    modport slave (
        input  req_read, req_write, req_handle, req_arg_a, req_arg_b,
        input  res_data, res_read_valid, res_write_ack,
        output req_read_valid, req_write_ack, req_data,
        output res_read_req, res_write_req, res_handle, res_arg_a, res_arg_b
    );

    modport master (
        output req_read, req_write, req_handle, req_arg_a, req_arg_b,
        output res_data, res_read_valid, res_write_ack,
        input  req_read_valid, req_write_ack, req_data,
        input  res_read_req, res_write_req, res_handle, res_arg_a, res_arg_b
    );
endinterface

// File: rtl/resource_arbiter.sv
// Round-robin arbiter sharing one external resource port among N_REQ branches,
// with a watchdog that force-completes a stalled transaction.
//
// state   | meaning
// IDLE    | no transaction; grant the next requester in round-robin order
// BUSY    | request presented to the resource; wait for matching response or timeout
// RELEASE | one quiet cycle so the served requester can drop its level request
module resource_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int HANDLE_WIDTH = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    resource_arbiter_if.slave        bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);
    localparam int IW = $clog2(N_REQ);
    // The watchdog is a down-counter loaded so it reaches zero in the
    // TIMEOUT-th BUSY cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, grant_q, grant_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [HANDLE_WIDTH-1:0] handle_q, handle_d;
    logic [DATA_WIDTH-1:0]   arg_a_q, arg_a_d, arg_b_q, arg_b_d, data_q, data_d;
    logic [N_REQ-1:0]        rd_valid_q, rd_valid_d, wr_ack_q, wr_ack_d;
    logic                    tmo_q, tmo_d;
    logic [N_REQ-1:0]        req_any;
    logic                    found;
    logic [IW-1:0]           sel;
    logic                    done_rd, done_wr, expired;

    assign req_any = bus.req_read | bus.req_write;
    // A response of the wrong type never matches the outstanding request.
    assign done_rd = rd_req_q & bus.res_read_valid;
    assign done_wr = wr_req_q & bus.res_write_ack;
    assign expired = (timer_q == '0);

    // Round-robin pick: first requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_any[i] && (IW'(i) >= ptr_q)) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_any[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    // Next-state and next-output logic; completion pulses default to zero.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        rd_req_d   = rd_req_q;
        wr_req_d   = wr_req_q;
        handle_d   = handle_q;
        arg_a_d    = arg_a_q;
        arg_b_d    = arg_b_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        rd_valid_d = '0;
        wr_ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = sel;
                    handle_d = bus.req_handle[sel*HANDLE_WIDTH +: HANDLE_WIDTH];
                    arg_a_d  = bus.req_arg_a[sel*DATA_WIDTH +: DATA_WIDTH];
                    arg_b_d  = bus.req_arg_b[sel*DATA_WIDTH +: DATA_WIDTH];
                    // Write wins when both request lines are high.
                    wr_req_d = bus.req_write[sel];
                    rd_req_d = ~bus.req_write[sel];
                    timer_d  = TIMER_LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (done_rd || done_wr || expired) begin
                    // A real response in the expiry cycle still counts as normal.
                    if (rd_req_q) begin
                        rd_valid_d[grant_q] = 1'b1;
                        data_d = done_rd ? bus.res_data : '0;
                    end else begin
                        wr_ack_d[grant_q] = 1'b1;
                        if (!done_wr) data_d = '0;
                    end
                    if (!(done_rd || done_wr)) tmo_d = 1'b1;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    ptr_d    = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = RELEASE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything holds while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            handle_q   <= '0;
            arg_a_q    <= '0;
            arg_b_q    <= '0;
            data_q     <= '0;
            tmo_q      <= 1'b0;
            rd_valid_q <= '0;
            wr_ack_q   <= '0;
        end else if (enable) begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            handle_q   <= handle_d;
            arg_a_q    <= arg_a_d;
            arg_b_q    <= arg_b_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    assign bus.res_read_req   = rd_req_q;
    assign bus.res_write_req  = wr_req_q;
    assign bus.res_handle     = handle_q;
    assign bus.res_arg_a      = arg_a_q;
    assign bus.res_arg_b      = arg_b_q;
    assign bus.req_read_valid = rd_valid_q;
    assign bus.req_write_ack  = wr_ack_q;
    assign bus.req_data       = data_q;
    assign grant_id           = grant_q;
    assign timeout_err        = tmo_q;
endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter with a short watchdog (TIMEOUT=8).
module tb_resource_arbiter;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] grant_id;
    logic       timeout_err;
    int         total;
    int         bad;
    int         g;
    int         exp_ids [5];
    logic       exp_wr  [4];

    resource_arbiter_if #(.N_REQ(4), .DATA_WIDTH(16), .HANDLE_WIDTH(8)) bus ();

    resource_arbiter #(
        .N_REQ(4), .DATA_WIDTH(16), .HANDLE_WIDTH(8), .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: observed=expired expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        total = 0;
        bad   = 0;
        exp_ids = '{0, 1, 2, 3, 0};
        exp_wr  = '{1'b0, 1'b1, 1'b1, 1'b1};
        reset  = 1'b1;
        enable = 1'b1;
        bus.req_read       = '0;
        bus.req_write      = '0;
        bus.req_handle     = '0;
        bus.req_arg_a      = '0;
        bus.req_arg_b      = '0;
        bus.res_data       = '0;
        bus.res_read_valid = 1'b0;
        bus.res_write_ack  = 1'b0;
        step();
        step();
        chk("rst_rd_req", 32'(bus.res_read_req), 0);
        chk("rst_wr_req", 32'(bus.res_write_req), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_data", 32'(bus.req_data), 0);
        chk("rst_handle", 32'(bus.res_handle), 0);
        reset = 1'b0;

        // Single read by requester 2
        bus.req_read[2] = 1'b1;
        bus.req_handle[2*8 +: 8]   = 8'h11;
        bus.req_arg_a[2*16 +: 16]  = 16'h1234;
        bus.req_arg_b[2*16 +: 16]  = 16'h5678;
        step();
        chk("t1_rd_req", 32'(bus.res_read_req), 1);
        chk("t1_wr_req", 32'(bus.res_write_req), 0);
        chk("t1_handle", 32'(bus.res_handle), 32'h11);
        chk("t1_arg_a", 32'(bus.res_arg_a), 32'h1234);
        chk("t1_arg_b", 32'(bus.res_arg_b), 32'h5678);
        chk("t1_grant", 32'(grant_id), 2);
        step();
        chk("t1_hold", 32'(bus.res_read_req), 1);
        bus.res_read_valid = 1'b1;
        bus.res_data       = 16'h8001;
        step();
        bus.res_read_valid = 1'b0;
        bus.req_read[2]    = 1'b0;
        chk("t1_rvalid", 32'(bus.req_read_valid), 32'b0100);
        chk("t1_data", 32'(bus.req_data), 32'h8001);
        chk("t1_rd_drop", 32'(bus.res_read_req), 0);
        step();
        chk("t1_pulse_end", 32'(bus.req_read_valid), 0);

        // Write by requester 1 with read_valid noise (ptr now 3)
        bus.req_write[1] = 1'b1;
        bus.req_handle[1*8 +: 8] = 8'h22;
        step();
        chk("t3_wr_req", 32'(bus.res_write_req), 1);
        chk("t3_rd_req", 32'(bus.res_read_req), 0);
        chk("t3_grant", 32'(grant_id), 1);
        chk("t3_handle", 32'(bus.res_handle), 32'h22);
        bus.res_read_valid = 1'b1;
        bus.res_data       = 16'hDEAD;
        step();
        chk("t3_noise_ack", 32'(bus.req_write_ack), 0);
        chk("t3_noise_rv", 32'(bus.req_read_valid), 0);
        chk("t3_noise_hold", 32'(bus.res_write_req), 1);
        bus.res_read_valid = 1'b0;
        bus.res_write_ack  = 1'b1;
        step();
        bus.res_write_ack = 1'b0;
        bus.req_write[1]  = 1'b0;
        chk("t3_ack", 32'(bus.req_write_ack), 32'b0010);
        chk("t3_rv", 32'(bus.req_read_valid), 0);
        chk("t3_wr_drop", 32'(bus.res_write_req), 0);
        chk("t3_data_kept", 32'(bus.req_data), 32'h8001);
        step();
        chk("t3_ack_end", 32'(bus.req_write_ack), 0);

        // Watchdog on requester 3 (ptr now 2)
        bus.req_read[3] = 1'b1;
        bus.req_handle[3*8 +: 8] = 8'h33;
        step();
        chk("t4_grant", 32'(grant_id), 3);
        chk("t4_rd_req", 32'(bus.res_read_req), 1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("t4_no_pulse", 32'(bus.req_read_valid), 0);
        end
        step();
        bus.req_read[3] = 1'b0;
        chk("t4_rvalid", 32'(bus.req_read_valid), 32'b1000);
        chk("t4_data", 32'(bus.req_data), 0);
        chk("t4_tmo", 32'(timeout_err), 1);
        chk("t4_rd_drop", 32'(bus.res_read_req), 0);
        step();
        chk("t4_pulse_end", 32'(bus.req_read_valid), 0);
        chk("t4_tmo_sticky", 32'(timeout_err), 1);

        // enable gating mid-BUSY on requester 0 (ptr now 0)
        bus.req_read[0] = 1'b1;
        bus.req_handle[0*8 +: 8] = 8'h44;
        step();
        chk("t5_grant", 32'(grant_id), 0);
        step();
        step();
        enable = 1'b0;
        bus.res_read_valid = 1'b1;
        bus.res_data       = 16'h0BAD;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_frozen_req", 32'(bus.res_read_req), 1);
            chk("t5_frozen_rv", 32'(bus.req_read_valid), 0);
            chk("t5_frozen_handle", 32'(bus.res_handle), 32'h44);
        end
        bus.res_read_valid = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_early_tmo", 32'(bus.req_read_valid), 0);
        end
        bus.res_read_valid = 1'b1;
        bus.res_data       = 16'h7777;
        step();
        bus.res_read_valid = 1'b0;
        bus.req_read[0]    = 1'b0;
        chk("t5_rvalid", 32'(bus.req_read_valid), 32'b0001);
        chk("t5_data", 32'(bus.req_data), 32'h7777);
        step();

        // Reset mid-BUSY (ptr now 1)
        bus.req_write[2] = 1'b1;
        bus.req_handle[2*8 +: 8] = 8'h55;
        step();
        chk("t6_wr_req", 32'(bus.res_write_req), 1);
        chk("t6_grant", 32'(grant_id), 2);
        reset = 1'b1;
        bus.req_write[2] = 1'b0;
        step();
        chk("t6_wr_drop", 32'(bus.res_write_req), 0);
        chk("t6_rd_req", 32'(bus.res_read_req), 0);
        chk("t6_grant0", 32'(grant_id), 0);
        chk("t6_tmo_clr", 32'(timeout_err), 0);
        chk("t6_handle", 32'(bus.res_handle), 0);
        chk("t6_ack", 32'(bus.req_write_ack), 0);
        chk("t6_data", 32'(bus.req_data), 0);
        reset = 1'b0;

        // Contention: all four request; requester 2 raises both lines
        bus.req_read  = 4'b0101;
        bus.req_write = 4'b1110;
        for (int i = 0; i < 4; i++) bus.req_handle[i*8 +: 8] = 8'(8'hA0 + i);
        for (int n = 0; n < 5; n++) begin
            g = exp_ids[n];
            step();
            chk("rr_grant", 32'(grant_id), 32'(g));
            chk("rr_wr_req", 32'(bus.res_write_req), 32'(exp_wr[g]));
            chk("rr_handle", 32'(bus.res_handle), 32'(32'hA0 + g));
            if (exp_wr[g]) begin
                bus.res_write_ack = 1'b1;
            end else begin
                bus.res_read_valid = 1'b1;
                bus.res_data       = 16'(32'h1000 + g);
            end
            step();
            bus.res_write_ack  = 1'b0;
            bus.res_read_valid = 1'b0;
            if (exp_wr[g]) begin
                chk("rr_ack", 32'(bus.req_write_ack), 32'(1) << g);
            end else begin
                chk("rr_rvalid", 32'(bus.req_read_valid), 32'(1) << g);
                chk("rr_data", 32'(bus.req_data), 32'(32'h1000 + g));
            end
            step();
        end
        bus.req_read  = '0;
        bus.req_write = '0;

        // Response in the same cycle as watchdog expiry (ptr now 1)
        bus.req_read[1] = 1'b1;
        bus.req_handle[1*8 +: 8] = 8'h66;
        step();
        chk("t7_grant", 32'(grant_id), 1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("t7_no_pulse", 32'(bus.req_read_valid), 0);
        end
        bus.res_read_valid = 1'b1;
        bus.res_data       = 16'h4242;
        step();
        bus.res_read_valid = 1'b0;
        bus.req_read[1]    = 1'b0;
        chk("t7_rvalid", 32'(bus.req_read_valid), 32'b0010);
        chk("t7_data", 32'(bus.req_data), 32'h4242);
        chk("t7_tmo", 32'(timeout_err), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
